// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-lane patterns used by the alignment checker.
package dmem_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_WAIT = 2'b01,
        DM_RESP = 2'b10
    } dm_state_e;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ALL  = 4'b1111;
    localparam logic [3:0] SEL_LO_H = 4'b0011;
    localparam logic [3:0] SEL_HI_H = 4'b1100;

    // One-hot lane enable for a single byte at the given byte offset.
    function automatic logic [3:0] byte_lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_responder_align_chk.sv
// Combinational legality check for one data-memory access: alignment of the
// byte offset against the access size, and lane enables consistent with both.
module dmem_align_chk
    import dmem_responder_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [3:0] sel,
    input  logic [1:0] size,
    output logic       legal
);

    // Reads only need natural alignment; writes also need the exact lane set.
    always_comb begin
        legal = 1'b0;
        if (sel == SEL_NONE) begin
            case (size)
                SIZE_B:  legal = 1'b1;
                SIZE_H:  legal = (addr[0] == 1'b0);
                SIZE_W:  legal = (addr == 2'b00);
                default: legal = 1'b0;
            endcase
        end else begin
            case (size)
                SIZE_B:  legal = (sel == byte_lane_mask(addr));
                SIZE_H:  legal = (addr[0] == 1'b0) &&
                                 (sel == (addr[1] ? SEL_HI_H : SEL_LO_H));
                SIZE_W:  legal = (addr == 2'b00) && (sel == SEL_ALL);
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: captures one request, waits WAIT_CYCLES, then commits
// a byte-lane write or returns the whole aligned read word with a one-cycle ack.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_e         r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lo;
    logic [3:0]        r_sel;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lo;
    logic [3:0]        w_sel;
    logic [1:0]        w_size;
    logic [31:0]       w_wdata;
    logic              w_legal;
    logic              w_enter_resp;
    logic              w_commit_wr;
    logic              w_commit_rd;
    logic              w_unused_addr;

    // Address bits above the array index alias and are intentionally dropped.
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    // With zero wait states the commit edge is the capture edge, so the live
    // inputs are the request; otherwise the captured copy is.
    always_comb begin
        if (r_state == DM_IDLE) begin
            w_idx   = addr[ADDR_W+1:2];
            w_lo    = addr[1:0];
            w_sel   = sel;
            w_size  = size;
            w_wdata = wdata;
        end else begin
            w_idx   = r_idx;
            w_lo    = r_lo;
            w_sel   = r_sel;
            w_size  = r_size;
            w_wdata = r_wdata;
        end
    end

    dmem_align_chk u_align_chk (
        .addr  (w_lo),
        .sel   (w_sel),
        .size  (w_size),
        .legal (w_legal)
    );

    // Identify the edge on which the FSM moves into RESP (the commit edge).
    always_comb begin
        case (r_state)
            DM_IDLE: w_enter_resp = req && (WAIT_CYCLES == 0);
            DM_WAIT: w_enter_resp = (r_cnt == 4'd0);
            default: w_enter_resp = 1'b0;
        endcase
    end

    assign w_commit_wr = w_enter_resp && w_legal && (w_sel != SEL_NONE) && !rst;
    assign w_commit_rd = w_enter_resp && w_legal && (w_sel == SEL_NONE);

    // Byte-lane array update; left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word register: loads only on a legal read commit, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_commit_rd) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    // Request FSM with registered ack/err; a reset mid-flight drops the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DM_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_lo    <= 2'b00;
            r_sel   <= 4'b0000;
            r_size  <= 2'b00;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                DM_IDLE: begin
                    if (req) begin
                        r_idx   <= addr[ADDR_W+1:2];
                        r_lo    <= addr[1:0];
                        r_sel   <= sel;
                        r_size  <= size;
                        r_wdata <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= DM_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= ~w_legal;
                        end else begin
                            r_state <= DM_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                DM_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= DM_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= ~w_legal;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DM_RESP: begin
                    r_state <= DM_IDLE;
                end
                default: begin
                    r_state <= DM_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = (r_state == DM_WAIT) || (r_state == DM_RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=1/ADDR_W=10 and
// WAIT_CYCLES=0/ADDR_W=4) checked every cycle against a transaction-timestamp
// model, plus directed scenarios with literal expectations.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, req0, rst1, req1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  sel0, sel1;
    logic [1:0]  size0, size1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, err0, busy0, ack1, err1, busy1;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst0), .req(req0), .addr(addr0), .sel(sel0), .size(size0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));

    dmem_responder #(.ADDR_W(4), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst1), .req(req1), .addr(addr1), .sel(sel1), .size(size1),
        .wdata(wdata1), .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    bit          m_active [2];
    int          m_cap    [2];
    logic [31:0] m_a      [2];
    logic [31:0] m_wd     [2];
    logic [3:0]  m_s      [2];
    logic [1:0]  m_sz     [2];
    logic [31:0] m_mem    [2][1024];
    bit   [3:0]  m_vld    [2][1024];
    logic [31:0] m_rdata  [2];
    bit          m_rknown [2];
    bit          e_ack    [2];
    bit          e_err    [2];

    function automatic int m_wait(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int m_words(input int k);
        return (k == 0) ? 1024 : 16;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Legal iff naturally aligned, and a write covers exactly the accessed bytes.
    function automatic bit m_legal(input logic [31:0] a, input logic [3:0] s, input logic [1:0] sz);
        int nb;
        int lo;
        nb = size_bytes(sz);
        lo = int'(a[1:0]);
        if (nb == 0) return 1'b0;
        if ((lo % nb) != 0) return 1'b0;
        if (s == 4'b0000) return 1'b1;
        return s == 4'(((1 << nb) - 1) << lo);
    endfunction

    task automatic model_step(input int k, input logic r, input logic rq, input logic [31:0] a,
                              input logic [3:0] s, input logic [1:0] sz, input logic [31:0] wd);
        bit just_done;
        int idx;
        just_done = 1'b0;
        if (r) begin
            m_active[k] = 1'b0;
            m_rdata[k]  = 32'd0;
            m_rknown[k] = 1'b1;
            e_ack[k]    = 1'b0;
            e_err[k]    = 1'b0;
            return;
        end
        if (m_active[k] && (cyc == m_cap[k] + m_wait(k) + 1)) begin
            m_active[k] = 1'b0;
            just_done   = 1'b1;
        end
        if (!m_active[k] && !just_done && rq) begin
            m_active[k] = 1'b1;
            m_cap[k]    = cyc;
            m_a[k] = a; m_s[k] = s; m_sz[k] = sz; m_wd[k] = wd;
        end
        e_ack[k] = m_active[k] && (cyc == m_cap[k] + m_wait(k));
        e_err[k] = 1'b0;
        if (e_ack[k]) begin
            idx = int'(m_a[k] >> 2) % m_words(k);
            if (!m_legal(m_a[k], m_s[k], m_sz[k])) begin
                e_err[k] = 1'b1;
            end else if (m_s[k] != 4'b0000) begin
                for (int l = 0; l < 4; l++) begin
                    if (m_s[k][l]) begin
                        m_mem[k][idx][8*l +: 8] = m_wd[k][8*l +: 8];
                        m_vld[k][idx][l] = 1'b1;
                    end
                end
            end else begin
                m_rdata[k]  = m_mem[k][idx];
                m_rknown[k] = (m_vld[k][idx] == 4'hF);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic a, input logic e, input logic b, input logic [31:0] rd);
        chk($sformatf("u%0d.ack", k), {31'd0, a}, {31'd0, e_ack[k]});
        chk($sformatf("u%0d.busy", k), {31'd0, b}, {31'd0, m_active[k]});
        if (e_ack[k]) chk($sformatf("u%0d.err", k), {31'd0, e}, {31'd0, e_err[k]});
        if (m_rknown[k]) chk($sformatf("u%0d.rdata", k), rd, m_rdata[k]);
    endtask

    // Model advances on each rising edge from the stable inputs, then checks outputs.
    always @(posedge clk) begin
        cyc++;
        model_step(0, rst0, req0, addr0, sel0, size0, wdata0);
        model_step(1, rst1, req1, addr1, sel1, size1, wdata1);
        #1;
        cmp(0, ack0, err0, busy0, rdata0);
        cmp(1, ack1, err1, busy1, rdata1);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input int k, input logic rq, input logic [31:0] a, input logic [3:0] s,
                          input logic [1:0] sz, input logic [31:0] wd);
        if (k == 0) begin
            req0 = rq; addr0 = a; sel0 = s; size0 = sz; wdata0 = wd;
        end else begin
            req1 = rq; addr1 = a; sel1 = s; size1 = sz; wdata1 = wd;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (((k == 0) ? busy0 : busy1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk($sformatf("u%0d.idle_timeout", k), 32'd0, 32'd1);
    endtask

    task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] s, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        rd = 32'd0; er = 1'b0; lat = 0;
        wait_idle(k);
        set_in(k, 1'b1, a, s, sz, wd);
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if ((k == 0) ? ack0 : ack1) begin
                got = 1'b1;
                rd  = (k == 0) ? rdata0 : rdata1;
                er  = (k == 0) ? err0 : err1;
            end
        end
        if (!got) chk($sformatf("u%0d.ack_timeout", k), 32'd0, 32'd1);
        @(negedge clk);
        set_in(k, 1'b0, 32'd0, 4'd0, 2'd0, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        set_in(0, 1'b0, 32'd0, 4'd0, 2'd0, 32'd0);
        set_in(1, 1'b0, 32'd0, 4'd0, 2'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset.ack0", {31'd0, ack0}, 32'd0);
        chk("reset.err0", {31'd0, err0}, 32'd0);
        chk("reset.busy0", {31'd0, busy0}, 32'd0);
        chk("reset.rdata0", rdata0, 32'd0);
        chk("reset.busy1", {31'd0, busy1}, 32'd0);
        chk("reset.rdata1", rdata1, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;

        // Preload the low 16 words of both arrays.
        for (int w = 0; w < 16; w++) begin
            do_req(0, 32'(w * 4), 4'hF, 2'b10, $urandom, rd, er, lat);
            do_req(1, 32'(w * 4), 4'hF, 2'b10, $urandom, rd, er, lat);
        end

        // Word write then read, one wait state.
        do_req(0, 32'h10, 4'hF, 2'b10, 32'hDEADBEEF, rd, er, lat);
        chk("wr_word.lat", 32'(lat), 32'd2);
        chk("wr_word.err", {31'd0, er}, 32'd0);
        do_req(0, 32'h10, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("rd_word.lat", 32'(lat), 32'd2);
        chk("rd_word.rdata", rd, 32'hDEADBEEF);

        // Byte merge into lane 2.
        do_req(0, 32'h12, 4'b0100, 2'b00, 32'h55555555, rd, er, lat);
        do_req(0, 32'h10, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("byte_merge.rdata", rd, 32'hDE55BEEF);

        // Halfword merge into upper half over zero.
        do_req(0, 32'h10, 4'hF, 2'b10, 32'h00000000, rd, er, lat);
        do_req(0, 32'h12, 4'b1100, 2'b01, 32'h12341234, rd, er, lat);
        do_req(0, 32'h10, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("half_merge.rdata", rd, 32'h12340000);

        // Misaligned read and lane-mismatched write are rejected.
        do_req(0, 32'h11, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("misalign_rd.err", {31'd0, er}, 32'd1);
        chk("misalign_rd.rdata", rd, 32'h12340000);
        do_req(0, 32'h10, 4'b1100, 2'b01, 32'hFFFFFFFF, rd, er, lat);
        chk("bad_lanes_wr.err", {31'd0, er}, 32'd1);
        do_req(0, 32'h1010, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("alias_rd.rdata", rd, 32'h12340000);
        chk("alias_rd.err", {31'd0, er}, 32'd0);

        // Zero wait states, req held high over two reads.
        do_req(1, 32'h10, 4'hF, 2'b10, 32'hA5A5A5A5, rd, er, lat);
        chk("w0_wr.lat", 32'(lat), 32'd1);
        do_req(1, 32'h14, 4'hF, 2'b10, 32'h0F0F0F0F, rd, er, lat);
        wait_idle(1);
        set_in(1, 1'b1, 32'h10, 4'h0, 2'b10, 32'd0);
        @(posedge clk); #1;
        chk("b2b.c1.ack", {31'd0, ack1}, 32'd1);
        chk("b2b.c1.rdata", rdata1, 32'hA5A5A5A5);
        @(negedge clk);
        set_in(1, 1'b1, 32'h14, 4'h0, 2'b10, 32'd0);
        @(posedge clk); #1;
        chk("b2b.c2.ack", {31'd0, ack1}, 32'd0);
        chk("b2b.c2.busy", {31'd0, busy1}, 32'd0);
        @(posedge clk); #1;
        chk("b2b.c3.ack", {31'd0, ack1}, 32'd1);
        chk("b2b.c3.rdata", rdata1, 32'h0F0F0F0F);
        @(negedge clk);
        set_in(1, 1'b0, 32'd0, 4'd0, 2'd0, 32'd0);
        @(posedge clk); #1;
        chk("b2b.c4.busy", {31'd0, busy1}, 32'd0);

        // Reset during WAIT of a write aborts it without commit.
        do_req(0, 32'h20, 4'hF, 2'b10, 32'hCAFEF00D, rd, er, lat);
        wait_idle(0);
        set_in(0, 1'b1, 32'h20, 4'hF, 2'b10, 32'h11111111);
        @(posedge clk); #1;
        chk("abort.busy_wait", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        rst0 = 1'b1;
        set_in(0, 1'b0, 32'd0, 4'd0, 2'd0, 32'd0);
        #1;
        chk("abort.ack", {31'd0, ack0}, 32'd0);
        chk("abort.busy", {31'd0, busy0}, 32'd0);
        chk("abort.rdata", rdata0, 32'd0);
        @(negedge clk);
        chk("abort.err", {31'd0, err0}, 32'd0);
        rst0 = 1'b0;
        do_req(0, 32'h20, 4'h0, 2'b10, 32'd0, rd, er, lat);
        chk("abort.readback", rd, 32'hCAFEF00D);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            int          k;
            int          nb;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [3:0]  s;
            k  = n % 2;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            nb = (sz == 2'b11) ? 8 : (1 << sz);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
            if ($urandom_range(0, 1) == 1) a = a | ($urandom << 12);
            s = 4'b0000;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 4) != 0) s = 4'(((1 << size_bytes(sz)) - 1) << a[1:0]);
                else s = 4'($urandom_range(1, 15));
            end
            do_req(k, a, s, sz, $urandom, rd, er, lat);
            chk($sformatf("rand%0d.lat", n), 32'(lat), 32'(m_wait(k) + 1));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data-memory interface driven by the MEM-stage load/store lane selector. It accepts one request at a time (word address, byte-lane enables `sel`, access `size`, replicated write data), checks alignment and lane consistency, inserts a configurable number of wait states, then commits byte-lane writes or returns the full 32-bit read word with a one-cycle `ack`. Lane extraction and sign extension of load data stay on the CPU side; this block always returns the whole aligned word.

## Interface
- `ADDR_W`, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: wait states between request capture and response, 0..15.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: request valid; held stable with all request fields until `ack`.
- `addr` input 32: byte address; bits [ADDR_W+1:2] index the array, higher bits ignored (aliasing).
- `sel` input 4: byte-lane write enables; `4'b0000` means read, nonzero means write.
- `size` input 2: `00` byte, `01` halfword, `10` word; `11` is illegal.
- `wdata` input 32: write data, already lane-replicated by the requester.
- `rdata` output 32: registered read word, valid in the `ack` cycle and held until the next read `ack`.
- `ack` output 1: one-cycle response strobe.
- `err` output 1: qualified by `ack`; 1 = request rejected, no array update.
- `busy` output 1: high from capture until the `ack` cycle inclusive.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req`=1 at a rising edge captures addr/sel/size/wdata and the check result; next state is WAIT if WAIT_CYCLES>0, else RESP. The wait counter loads WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at 0, the next state is RESP.
- Commit happens on the edge entering RESP. If the request is legal and a write, each byte lane i with sel[i]=1 is updated with wdata[8i+7:8i]. If it is legal and a read, `rdata` loads the array word. On an illegal request neither the array nor `rdata` changes.
- RESP: `ack`=1 and `err`=check result for exactly one cycle; next state is IDLE.
- Legal read: size `10` with addr[1:0]=00; size `01` with addr[0]=0; size `00` with any addr.
- Legal write: size `10` requires sel=1111 and addr[1:0]=00. Size `01` requires addr[0]=0, with sel=0011 when addr[1]=0 or sel=1100 when addr[1]=1. Size `00` requires sel to be one-hot at lane addr[1:0].
- Anything else, including size `11`, is illegal and sets `err`.
- `req` is sampled only in IDLE. `req` still high in the cycle after `ack` is a new request.
- Array contents are not reset. Contents are undefined until written.

## Timing
- Reset values: `ack`=0, `err`=0, `busy`=0, `rdata`=0; FSM enters IDLE and the counter is cleared.
- Latency: `ack` is asserted WAIT_CYCLES+1 cycles after the capture edge. With WAIT_CYCLES=0, `ack` comes in the cycle right after capture.
- Back-to-back throughput: one request per WAIT_CYCLES+2 cycles, because the IDLE capture cycle follows each `ack`.
- Read-after-write: a read captured after a write's `ack` returns the written data.
- Reset mid-operation (WAIT or RESP): the request is aborted and no `ack` is issued. A pending write is not committed, because commit happens on the RESP-entry edge.
- `busy` is combinational from state: 1 in WAIT and RESP, and 0 in IDLE.

## Structure
- Add to `defines.h`: `SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10, plus state encodings `DM_IDLE`, `DM_WAIT`, `DM_RESP`.
- One combinational sub-module, `dmem_align_chk`: inputs addr[1:0], sel, size; output `legal`. It is unit-testable on its own.
- Array is inferred as a `reg [31:0]` memory with per-byte write enables, for BRAM inference.

## Test plan
- Word write then read, WAIT_CYCLES=1: write addr=0x10, sel=1111, size=10, wdata=0xDEADBEEF gives `ack` 2 cycles after capture with err=0. Reading 0x10 then gives rdata=0xDEADBEEF.
- Byte merge: preload 0x10 with 0xDEADBEEF, then write addr=0x12, sel=0100, size=00, wdata=0x55555555. A read of 0x10 returns 0xDE55BEEF.
- Halfword merge: write addr=0x12, sel=1100, size=01, wdata=0x12341234 over 0x00000000. Reading returns 0x12340000.
- Misaligned: read addr=0x11 size=10 gives ack=1, err=1, rdata unchanged. Write addr=0x10, size=01, sel=1100 gives err=1 and the array is unchanged.
- WAIT_CYCLES=0 with `req` held high over two different reads gives `ack` on cycles 1 and 3 after the first capture, with busy low in cycles 2 and 4.
- Reset asserted in WAIT during a write to 0x20 gives no `ack` and all outputs at 0. A later read of 0x20 returns the prior contents.
